// File: rtl/adder_arbiter_pkg.sv
// Shared types and constants for the two-requester adder arbiter.
// Imported by the arbiter top.
package adder_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage : adder_arbiter_pkg

// File: rtl/adder.sv
// Combinational signed adder with negative/zero/even flags derived from the wrapped sum.
// Overflow is deliberately not reported.
module adder #(
  parameter int NBITS = 8
) (
  input  logic [NBITS-1:0] a_i,
  input  logic [NBITS-1:0] b_i,
  output logic [NBITS-1:0] s_o,
  output logic             n_o,
  output logic             z_o,
  output logic             p_o
);

  logic [NBITS-1:0] sum_s;

  assign sum_s = a_i + b_i;
  assign s_o   = sum_s;
  assign n_o   = sum_s[NBITS-1];
  assign z_o   = (sum_s == {NBITS{1'b0}});
  assign p_o   = ~sum_s[0];

endmodule : adder

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder between two valid/ready requesters;
// captures the granted pair, adds it, and holds the result until consumed.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [NBITS-1:0] req0_a,
  input  logic [NBITS-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [NBITS-1:0] req1_a,
  input  logic [NBITS-1:0] req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [NBITS-1:0] resp_s,
  output logic             resp_n,
  output logic             resp_z,
  output logic             resp_p
);

  state_t           state_q;
  logic             last_grant_q;
  logic [NBITS-1:0] op_a_q;
  logic [NBITS-1:0] op_b_q;
  logic             op_id_q;
  logic             resp_valid_q;
  logic             resp_id_q;
  logic [NBITS-1:0] resp_s_q;
  logic             resp_n_q;
  logic             resp_z_q;
  logic             resp_p_q;

  logic             grant_valid_s;
  logic             grant_id_s;
  logic             accept_s;
  logic [NBITS-1:0] grant_a_s;
  logic [NBITS-1:0] grant_b_s;
  logic [NBITS-1:0] sum_s;
  logic             sum_n_s;
  logic             sum_z_s;
  logic             sum_p_s;

  // On a tie the requester that did not win last time is favoured.
  always_comb begin
    grant_valid_s = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id_s = ~last_grant_q;
    end else if (req1_valid) begin
      grant_id_s = REQ1;
    end else begin
      grant_id_s = REQ0;
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    if (grant_id_s == REQ1) begin
      grant_a_s = req1_a;
      grant_b_s = req1_b;
    end else begin
      grant_a_s = req0_a;
      grant_b_s = req0_b;
    end
  end

  assign accept_s   = (state_q == IDLE) && grant_valid_s;
  assign req0_ready = accept_s && (grant_id_s == REQ0);
  assign req1_ready = accept_s && (grant_id_s == REQ1);

  adder #(
    .NBITS (NBITS)
  ) u_adder (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .s_o (sum_s),
    .n_o (sum_n_s),
    .z_o (sum_z_s),
    .p_o (sum_p_s)
  );

  // Control FSM with capture and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= REQ1;
      op_a_q       <= {NBITS{1'b0}};
      op_b_q       <= {NBITS{1'b0}};
      op_id_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_s_q     <= {NBITS{1'b0}};
      resp_n_q     <= 1'b0;
      resp_z_q     <= 1'b0;
      resp_p_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            op_a_q       <= grant_a_s;
            op_b_q       <= grant_b_s;
            op_id_q      <= grant_id_s;
            last_grant_q <= grant_id_s;
            state_q      <= EXEC;
          end else begin
            state_q      <= IDLE;
          end
        end
        EXEC: begin
          resp_s_q     <= sum_s;
          resp_n_q     <= sum_n_s;
          resp_z_q     <= sum_z_s;
          resp_p_q     <= sum_p_s;
          resp_id_q    <= op_id_q;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end else begin
            state_q      <= RESP;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_s     = resp_s_q;
  assign resp_n     = resp_n_q;
  assign resp_z     = resp_z_q;
  assign resp_p     = resp_p_q;

endmodule : adder_arbiter

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed test-plan cases plus randomized
// traffic compared against a transaction-level arithmetic/round-robin model.
module tb_adder_arbiter;

  localparam int NB = 8;

  logic          clk;
  logic          rst_n;
  logic          req0_valid;
  logic          req0_ready;
  logic [NB-1:0] req0_a;
  logic [NB-1:0] req0_b;
  logic          req1_valid;
  logic          req1_ready;
  logic [NB-1:0] req1_a;
  logic [NB-1:0] req1_b;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_id;
  logic [NB-1:0] resp_s;
  logic          resp_n;
  logic          resp_z;
  logic          resp_p;

  int vec_cnt;
  int err_cnt;
  int last_winner;

  adder_arbiter #(
    .NBITS (NB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_s     (resp_s),
    .resp_n     (resp_n),
    .resp_z     (resp_z),
    .resp_p     (resp_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: signed integer sum reduced modulo 2^NB into [0, 2^NB).
  function automatic int ref_sum(input logic [NB-1:0] a, input logic [NB-1:0] b);
    int sa;
    int sb;
    int r;
    sa = (a >= (1 << (NB - 1))) ? int'(a) - (1 << NB) : int'(a);
    sb = (b >= (1 << (NB - 1))) ? int'(b) - (1 << NB) : int'(b);
    r  = (sa + sb) % (1 << NB);
    if (r < 0) r = r + (1 << NB);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    req0_valid = 1'($urandom);
    req1_valid = 1'($urandom);
    req0_a = NB'($urandom);
    req0_b = NB'($urandom);
    req1_a = NB'($urandom);
    req1_b = NB'($urandom);
  endtask

  task automatic check_resp(input string tag, input int winner, input int sum);
    check({tag, "_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_id"}, 32'(resp_id), 32'(winner));
    check({tag, "_s"}, 32'(resp_s), 32'(sum));
    check({tag, "_n"}, 32'(resp_n), (sum >= (1 << (NB - 1))) ? 32'd1 : 32'd0);
    check({tag, "_z"}, 32'(resp_z), (sum == 0) ? 32'd1 : 32'd0);
    check({tag, "_p"}, 32'(resp_p), (sum % 2 == 0) ? 32'd1 : 32'd0);
  endtask

  // One complete transaction; at least one valid must be set. Called in IDLE at posedge+1.
  task automatic do_op(input logic v0, input logic [NB-1:0] a0, input logic [NB-1:0] b0,
                       input logic v1, input logic [NB-1:0] a1, input logic [NB-1:0] b1,
                       input int hold);
    int winner;
    int sum;
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    #1;
    if (v0 && v1) winner = 1 - last_winner;
    else          winner = v1 ? 1 : 0;
    sum = (winner == 1) ? ref_sum(a1, b1) : ref_sum(a0, b0);
    check("grant_r0", 32'(req0_ready), (winner == 0) ? 32'd1 : 32'd0);
    check("grant_r1", 32'(req1_ready), (winner == 1) ? 32'd1 : 32'd0);
    step();
    last_winner = winner;
    scramble_inputs();
    resp_ready = (hold == 0);
    #1;
    check("exec_rdy", 32'({req0_ready, req1_ready}), 32'd0);
    check("exec_val", 32'(resp_valid), 32'd0);
    step();
    check_resp("resp", winner, sum);
    for (int i = 0; i < hold; i++) begin
      scramble_inputs();
      #1;
      check("hold_rdy", 32'({req0_ready, req1_ready}), 32'd0);
      step();
      check_resp("hold", winner, sum);
    end
    resp_ready = 1'b1;
    step();
    check("drop_val", 32'(resp_valid), 32'd0);
    check("keep_s", 32'(resp_s), 32'(sum));
    resp_ready = 1'($urandom);
  endtask

  initial begin
    int v0;
    int v1;
    vec_cnt = 0;
    err_cnt = 0;
    last_winner = 1;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    resp_ready = 1'b0;
    #12;
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_s", 32'(resp_s), 32'd0);
    check("rst_flags", 32'({resp_id, resp_n, resp_z, resp_p}), 32'd0);
    rst_n = 1'b1;
    step();

    do_op(1'b1, 8'd100, 8'd100, 1'b0, 8'd0, 8'd0, 0);
    check("plan_c8", 32'(resp_s), 32'hC8);
    do_op(1'b0, 8'd0, 8'd0, 1'b1, 8'd5, 8'hFB, 1);
    check("plan_zero", 32'(resp_s), 32'h00);
    do_op(1'b1, 8'd3, 8'd4, 1'b0, 8'd0, 8'd0, 0);
    do_op(1'b1, 8'h80, 8'hFF, 1'b0, 8'd0, 8'd0, 0);
    check("plan_wrap", 32'(resp_s), 32'h7F);

    for (int i = 0; i < 4; i++) begin
      do_op(1'b1, NB'(10 + i), NB'(20 * i), 1'b1, NB'(50 + i), NB'(7 * i), 0);
    end
    do_op(1'b1, 8'd1, 8'd2, 1'b1, 8'd9, 8'd9, 5);

    // Reset while the first operation is in EXEC: nothing may come out afterwards.
    req0_valid = 1'b1; req0_a = 8'd11; req0_b = 8'd22;
    req1_valid = 1'b0;
    step();
    req0_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_val", 32'(resp_valid), 32'd0);
    check("mid_rst_s", 32'(resp_s), 32'd0);
    check("mid_rst_rdy", 32'({req0_ready, req1_ready}), 32'd0);
    last_winner = 1;
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("no_stale", 32'(resp_valid), 32'd0);
    end
    do_op(1'b1, 8'd7, 8'd8, 1'b1, 8'd1, 8'd1, 0);
    check("post_rst_tie", 32'(resp_id), 32'd0);

    for (int n = 0; n < 60; n++) begin
      v0 = int'($urandom_range(0, 2));
      v1 = int'($urandom_range(0, 2));
      if (v0 == 0 && v1 == 0) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = NB'($urandom);
        req1_a = NB'($urandom);
        #1;
        check("idle_rdy", 32'({req0_ready, req1_ready}), 32'd0);
        step();
        check("idle_val", 32'(resp_valid), 32'd0);
      end else begin
        do_op(v0 != 0, NB'($urandom), NB'($urandom), v1 != 0, NB'($urandom), NB'($urandom),
              int'($urandom_range(0, 3)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule : tb_adder_arbiter
